// File: rtl/sp_ram_pkg.sv
// Shared types and width helpers for the banked single-port RAM.
package sp_ram_pkg;

    typedef enum logic {CLEAR, READY} state_t;

    function automatic int bank_idx_w(input int num_banks);
        return (num_banks > 1) ? $clog2(num_banks) : 1;
    endfunction

    function automatic int row_w(input int bank_words);
        return (bank_words > 1) ? $clog2(bank_words) : 1;
    endfunction

    function automatic int byte_cnt(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/sp_ram_bank_gen.sv
// One word-wide SRAM bank: synchronous read, per-byte write enables, 1-cycle latency.
module sp_ram_bank_gen
    import sp_ram_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int BANK_WORDS = 8192,
    localparam int ROW_W     = row_w(BANK_WORDS),
    localparam int NB        = byte_cnt(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic [NB-1:0]         we,
    input  logic [ROW_W-1:0]      row,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

`ifdef SYNTHESIS
    sram_sp_macro #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (BANK_WORDS)
    ) u_macro (
        .clk   (clk),
        .en    (en),
        .we    (we),
        .addr  (row),
        .wdata (wdata),
        .rdata (rdata)
    );
`else
    logic [DATA_WIDTH-1:0] mem [BANK_WORDS];

    // rdata only moves on reads, so it holds the last read word across writes and sweeps
    always_ff @(posedge clk) begin
        if (en) begin
            if (|we) begin
                for (int i = 0; i < NB; i++) begin
                    if (we[i]) mem[row][8*i +: 8] <= wdata[8*i +: 8];
                end
            end else begin
                rdata <= mem[row];
            end
        end
    end
`endif

endmodule

// File: rtl/sp_ram_banked.sv
// Banked single-port RAM with req/gnt/rvalid handshake, range check and zeroing sweep.
module sp_ram_banked
    import sp_ram_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int BANK_WORDS     = 8192,
    parameter int NUM_BANKS      = 4,
    parameter int ADDR_WIDTH     = 17,
    parameter int OUT_REG        = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_i,
    output logic                    gnt_o,
    input  logic                    we_i,
    input  logic [DATA_WIDTH/8-1:0] be_i,
    input  logic [ADDR_WIDTH-1:0]   addr_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    output logic                    rvalid_o,
    output logic [DATA_WIDTH-1:0]   rdata_o,
    output logic                    err_o,
    input  logic                    clear_i,
    output logic                    busy_o
);

    localparam int NB     = byte_cnt(DATA_WIDTH);
    localparam int OFF    = $clog2(NB);
    localparam int WORD_W = ADDR_WIDTH - OFF;
    localparam int ROW_W  = row_w(BANK_WORDS);
    localparam int BANK_W = bank_idx_w(NUM_BANKS);

    state_t           state;
    logic [ROW_W-1:0] idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
            busy_o <= (CLEAR_ON_RESET != 0);
            idx    <= '0;
        end else begin
            case (state)
                READY: begin
                    if (clear_i) begin
                        state  <= CLEAR;
                        busy_o <= 1'b1;
                        idx    <= '0;
                    end
                end
                CLEAR: begin
                    if (idx == ROW_W'(BANK_WORDS - 1)) begin
                        state  <= READY;
                        busy_o <= 1'b0;
                        idx    <= '0;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: state <= READY;
            endcase
        end
    end

    assign gnt_o = req_i & (state == READY) & ~clear_i;

    // Address decode: contiguous banks, bank number in the upper word bits
    logic [WORD_W-1:0] word;
    logic [WORD_W-1:0] bank_full;
    logic [BANK_W-1:0] bank_idx;
    logic [ROW_W-1:0]  row;
    logic              err;

    assign word      = WORD_W'(addr_i >> OFF);
    assign bank_full = word >> ROW_W;
    assign bank_idx  = BANK_W'(bank_full);
    assign row       = word[ROW_W-1:0];
    assign err       = (32'(bank_full) >= 32'(NUM_BANKS));

    generate
        if (OFF > 0) begin : g_unused
            logic unused_low;
            assign unused_low = ^addr_i[OFF-1:0];
        end
    endgenerate

    logic                                  sweep;
    logic [NB-1:0]                         bank_we;
    logic [ROW_W-1:0]                      bank_row;
    logic [DATA_WIDTH-1:0]                 bank_wdata;
    logic [NUM_BANKS-1:0]                  bank_en;
    logic [NUM_BANKS-1:0][DATA_WIDTH-1:0]  bank_rdata;

    assign sweep      = (state == CLEAR);
    assign bank_we    = sweep ? '1 : (we_i ? be_i : '0);
    assign bank_row   = sweep ? idx : row;
    assign bank_wdata = sweep ? '0 : wdata_i;

    generate
        for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
            assign bank_en[b] = sweep | (gnt_o & ~err & (bank_idx == BANK_W'(b)));

            sp_ram_bank_gen #(
                .DATA_WIDTH (DATA_WIDTH),
                .BANK_WORDS (BANK_WORDS)
            ) u_bank (
                .clk   (clk),
                .en    (bank_en[b]),
                .we    (bank_we),
                .row   (bank_row),
                .wdata (bank_wdata),
                .rdata (bank_rdata[b])
            );
        end
    endgenerate

    // Stage 1 fields hold between grants so the unregistered output stays stable
    logic              s1_vld, s1_we, s1_err;
    logic [BANK_W-1:0] s1_bank;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld  <= 1'b0;
            s1_we   <= 1'b1;
            s1_err  <= 1'b0;
            s1_bank <= '0;
        end else begin
            s1_vld <= gnt_o;
            if (gnt_o) begin
                s1_we   <= we_i;
                s1_err  <= err;
                s1_bank <= bank_idx;
            end
        end
    end

    logic [DATA_WIDTH-1:0] rd_sel;
    logic [DATA_WIDTH-1:0] resp_data;

    always_comb begin
        rd_sel = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (s1_bank == BANK_W'(b)) rd_sel = bank_rdata[b];
        end
    end

    assign resp_data = (s1_we | s1_err) ? '0 : rd_sel;

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic                  rvalid_q, err_q;
            logic [DATA_WIDTH-1:0] rdata_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rvalid_q <= 1'b0;
                    err_q    <= 1'b0;
                    rdata_q  <= '0;
                end else begin
                    rvalid_q <= s1_vld;
                    err_q    <= s1_vld & s1_err;
                    if (s1_vld) rdata_q <= resp_data;
                end
            end

            assign rvalid_o = rvalid_q;
            assign err_o    = err_q;
            assign rdata_o  = rdata_q;
        end else begin : g_out_comb
            assign rvalid_o = s1_vld;
            assign err_o    = s1_vld & s1_err;
            assign rdata_o  = resp_data;
        end
    endgenerate

endmodule

// File: tb/tb_sp_ram_banked.sv
// Scoreboard bench: random and directed accesses against a flat word-array model.
module tb_sp_ram_banked;

    localparam int DW  = 32;
    localparam int BW  = 16;
    localparam int NBK = 3;
    localparam int AW  = 8;
    localparam int LAT = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req = 1'b0;
    logic          we = 1'b0;
    logic          clear = 1'b0;
    logic [3:0]    be = '0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] wdata = '0;
    logic          gnt, rvalid, err, busy;
    logic [DW-1:0] rdata;

    sp_ram_banked #(
        .DATA_WIDTH     (DW),
        .BANK_WORDS     (BW),
        .NUM_BANKS      (NBK),
        .ADDR_WIDTH     (AW),
        .OUT_REG        (1),
        .CLEAR_ON_RESET (1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_i    (req),
        .gnt_o    (gnt),
        .we_i     (we),
        .be_i     (be),
        .addr_i   (addr),
        .wdata_i  (wdata),
        .rvalid_o (rvalid),
        .rdata_o  (rdata),
        .err_o    (err),
        .clear_i  (clear),
        .busy_o   (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0] data;
        logic          err;
        int            gcyc;
    } exp_t;

    exp_t          q[$];
    logic [DW-1:0] mem [NBK*BW];
    int            total = 0;
    int            bad = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NBK*BW; i++) mem[i] = '0;
    endtask

    // Expected response of a granted access, from the address map and byte-enable rules
    task automatic model_op(input logic w, input logic [3:0] b, input logic [AW-1:0] a,
                            input logic [DW-1:0] d);
        exp_t e;
        int   wi;
        wi     = int'(a) / (DW/8);
        e.gcyc = cyc;
        e.err  = 1'b0;
        e.data = '0;
        if (wi >= NBK*BW) begin
            e.err = 1'b1;
        end else if (w) begin
            for (int i = 0; i < DW/8; i++)
                if (b[i]) mem[wi][8*i +: 8] = d[8*i +: 8];
        end else begin
            e.data = mem[wi];
        end
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (rvalid) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_rvalid: got 1 want 0 (cycle %0d)", cyc);
                end else begin
                    e = q.pop_front();
                    chk("rdata", rdata, e.data);
                    chk("err", {31'b0, err}, {31'b0, e.err});
                    chk("latency", cyc, e.gcyc + LAT);
                end
            end else begin
                chk("err_idle", {31'b0, err}, 32'd0);
            end
        end
    end

    task automatic idle();
        @(negedge clk);
        req   = 1'b0;
        clear = 1'b0;
    endtask

    task automatic issue(input logic w, input logic [3:0] b, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
        int n;
        n = 0;
        @(negedge clk);
        req = 1'b1; we = w; be = b; addr = a; wdata = d;
        #1;
        chk("gnt_ready", {31'b0, gnt}, 32'd1);
        while (!gnt && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (gnt) model_op(w, b, a, d);
        else begin
            total++;
            bad++;
            $display("FAIL grant_timeout: got 0 want 1 (cycle %0d)", cyc);
        end
    endtask

    // Hold a read request through the sweep; it must never be granted while busy
    task automatic sweep_wait();
        int n;
        n = 0;
        req = 1'b1; we = 1'b0; addr = '0;
        #1;
        while (busy && n < 100) begin
            chk("gnt_busy", {31'b0, gnt}, 32'd0);
            n++;
            @(negedge clk);
            #1;
        end
        req = 1'b0;
        chk("sweep_len", n, BW);
    endtask

    initial begin
        model_clear();
        req = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_rvalid", {31'b0, rvalid}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd1);
        chk("rst_gnt", {31'b0, gnt}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        sweep_wait();

        // Whole address space, including the unpopulated fourth bank
        for (int a = 0; a < 64; a++) issue(1'b0, 4'h0, AW'(a*4), '0);
        idle();

        issue(1'b1, 4'b0101, 8'h44, 32'hDEADBEEF);
        issue(1'b0, 4'h0, 8'h44, '0);
        idle();

        issue(1'b0, 4'h0, 8'h00, '0);
        issue(1'b0, 4'h0, 8'h40, '0);
        issue(1'b0, 4'h0, 8'h80, '0);
        issue(1'b0, 4'h0, 8'hC0, '0);
        issue(1'b1, 4'h0, 8'h44, 32'hFFFFFFFF);
        issue(1'b0, 4'h0, 8'h44, '0);
        idle();

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) idle();
            else issue(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                       AW'($urandom_range(0, 255)), $urandom);
        end
        idle();

        // Clear tie: outstanding read still answers with pre-clear data
        issue(1'b1, 4'hF, 8'h48, 32'h12345678);
        issue(1'b0, 4'h0, 8'h48, '0);
        @(negedge clk);
        clear = 1'b1; req = 1'b1; we = 1'b0; addr = 8'h48;
        #1;
        chk("gnt_clear", {31'b0, gnt}, 32'd0);
        model_clear();
        @(negedge clk);
        clear = 1'b0;
        sweep_wait();
        issue(1'b0, 4'h0, 8'h48, '0);
        issue(1'b0, 4'h0, 8'h44, '0);
        idle();

        // Reset mid-burst
        issue(1'b1, 4'hF, 8'h10, 32'hCAFEF00D);
        issue(1'b0, 4'h0, 8'h10, '0);
        issue(1'b0, 4'h0, 8'h14, '0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        req = 1'b0;
        #1;
        chk("midrst_rvalid", {31'b0, rvalid}, 32'd0);
        chk("midrst_rdata", rdata, 32'd0);
        chk("midrst_err", {31'b0, err}, 32'd0);
        q.delete();
        model_clear();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        sweep_wait();
        issue(1'b0, 4'h0, 8'h10, '0);
        for (int i = 0; i < 40; i++)
            issue(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                  AW'($urandom_range(0, 255)), $urandom);
        idle();
        repeat (5) idle();
        chk("queue_empty", q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
